// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude compare path.
// State encoding, default width and relation encoding.
package cmp_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam int CMP_W = 8;

    typedef enum logic [1:0] {
        GT,
        LT,
        EQ
    } rel_t;

endpackage

// File: rtl/serial_cmp8.sv
// Bit-serial receiver: reassembles MSB-first operands and
// registers the x>y / x<y / x==y relation with a done strobe.
module serial_cmp8
    import cmp_pkg::*;
#(
    parameter int W  = CMP_W,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         bit_valid,
    input  logic         sx,
    input  logic         sy,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] x_q,
    output logic [W-1:0] y_q,
    output logic         xgy,
    output logic         xsy,
    output logic         xey
);

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic          decided;
    logic          gt;
    logic          load;
    logic          shift;
    logic          fin;
    logic          dec_n;
    logic          gt_n;

    // First differing bit pair (MSB-first) settles the relation.
    assign dec_n = decided | (sx ^ sy);
    assign gt_n  = decided ? gt : sx;
    assign busy  = (state == SHIFT);

    always_comb begin
        state_d = state;
        load    = 1'b0;
        shift   = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_valid) begin
                    shift = 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            decided <= 1'b0;
            gt      <= 1'b0;
            done    <= 1'b0;
            xgy     <= 1'b0;
            xsy     <= 1'b0;
            xey     <= 1'b0;
        end else begin
            done <= fin;
            if (load) begin
                cnt     <= '0;
                x_q     <= '0;
                y_q     <= '0;
                decided <= 1'b0;
                gt      <= 1'b0;
            end else if (shift) begin
                cnt     <= cnt + CW'(1);
                x_q     <= {x_q[W-2:0], sx};
                y_q     <= {y_q[W-2:0], sy};
                decided <= dec_n;
                gt      <= gt_n;
            end
            if (fin) begin
                xgy <= dec_n & gt_n;
                xsy <= dec_n & ~gt_n;
                xey <= ~dec_n;
            end
        end
    end

endmodule

// File: tb/tb_serial_cmp8.sv
// Directed self-checking bench for serial_cmp8.
module tb_serial_cmp8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       bit_valid;
    logic       sx;
    logic       sy;
    logic       busy;
    logic       done;
    logic [7:0] x_q;
    logic [7:0] y_q;
    logic       xgy;
    logic       xsy;
    logic       xey;

    int checks   = 0;
    int failures = 0;
    int nd;

    always #5 clk = ~clk;

    serial_cmp8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .bit_valid (bit_valid),
        .sx        (sx),
        .sy        (sy),
        .busy      (busy),
        .done      (done),
        .x_q       (x_q),
        .y_q       (y_q),
        .xgy       (xgy),
        .xsy       (xsy),
        .xey       (xey)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_res(input string tag, input logic [7:0] x,
                           input logic [7:0] y);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_xgy"}, 32'(xgy), 32'(x > y));
        chk({tag, "_xsy"}, 32'(xsy), 32'(x < y));
        chk({tag, "_xey"}, 32'(xey), 32'(x == y));
        chk({tag, "_xq"}, 32'(x_q), 32'(x));
        chk({tag, "_yq"}, 32'(y_q), 32'(y));
    endtask

    // Called at a negedge; drives start now. Ends at the negedge
    // after the last pair's sampling edge (the expected done cycle).
    task automatic xfer(input logic [7:0] x, input logic [7:0] y,
                        input int gapmax, input logic stray,
                        output int ndone);
        ndone     = 0;
        start     = 1'b1;
        bit_valid = stray;
        sx        = 1'b1;
        sy        = 1'b0;
        tick();
        start     = 1'b0;
        abort     = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 7; i >= 0; i--) begin
            int g;
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            for (int k = 0; k < g; k++) begin
                bit_valid = 1'b0;
                sx        = ~x[i];
                sy        = x[i];
                tick();
                if (done) ndone++;
            end
            bit_valid = 1'b1;
            sx        = x[i];
            sy        = y[i];
            tick();
            if (done) ndone++;
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        bit_valid = 1'b0;
        sx        = 1'b0;
        sy        = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'({xgy, xsy, xey}), 32'd0);
        chk("rst_xq", 32'(x_q), 32'd0);
        rst_n = 1'b1;
        tick();

        // Equal operands; stray pair and abort in start cycle ignored.
        abort = 1'b1;
        xfer(8'h01, 8'h01, 0, 1'b1, nd);
        chk("eq_ndone", 32'(nd), 32'd1);
        chk_res("eq", 8'h01, 8'h01);
        tick();
        chk("eq_pulse", 32'(done), 32'd0);

        xfer(8'hA5, 8'h5A, 0, 1'b0, nd);
        chk("msb_ndone", 32'(nd), 32'd1);
        chk_res("msb", 8'hA5, 8'h5A);
        tick();

        xfer(8'h10, 8'h11, 0, 1'b0, nd);
        chk_res("lsb", 8'h10, 8'h11);
        tick();

        xfer(8'h10, 8'h11, 3, 1'b0, nd);
        chk("gap_ndone", 32'(nd), 32'd1);
        chk_res("gap", 8'h10, 8'h11);
        tick();
        chk("gap_pulse", 32'(done), 32'd0);

        // Establish xgy, then abort after 4 pairs.
        xfer(8'hC0, 8'h3F, 0, 1'b0, nd);
        chk_res("pre_abort", 8'hC0, 8'h3F);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            sx        = 1'b0;
            sy        = 1'b1;
            tick();
        end
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        bit_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_xgy", 32'(xgy), 32'd1);
        chk("abort_xsy", 32'(xsy), 32'd0);
        tick();
        chk("abort_done2", 32'(done), 32'd0);

        // Async reset mid-transfer after 5 pairs.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            sx        = 1'b1;
            sy        = 1'b0;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_flags", 32'({xgy, xsy, xey}), 32'd0);
        chk("arst_xq", 32'(x_q), 32'd0);
        bit_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_nodone", 32'(done), 32'd0);
        chk("arst_idle", 32'(busy), 32'd0);

        xfer(8'h7E, 8'h7E, 0, 1'b0, nd);
        chk_res("fresh", 8'h7E, 8'h7E);

        // Restart in the done cycle, back to back.
        xfer(8'hFF, 8'h00, 0, 1'b0, nd);
        chk_res("b2b_a", 8'hFF, 8'h00);
        xfer(8'h00, 8'hFF, 0, 1'b0, nd);
        chk_res("b2b_b", 8'h00, 8'hFF);
        tick();
        chk("b2b_pulse", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
